// File: rtl/midi_poly_fsm.sv
// Polyphonic MIDI note parser and voice allocator: running status, re-trigger, lowest-free allocation, round-robin stealing.
// Outputs are registered with 1-cycle latency from the final data byte. Define MIDI_OMNI_EN to accept note messages on all channels.
module midi_poly_fsm #(
    parameter int NUM_VOICES = 4,
    parameter int CHANNEL    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    new_byte_valid,
    input  logic [7:0]              new_byte_value,
    output logic [7*NUM_VOICES-1:0] note_values,
    output logic [7*NUM_VOICES-1:0] velocity_values,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic                    msg_valid,
    output logic                    voice_stolen
);

    localparam int PW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [2:0] {
        K_NONE,
        K_NOTE_ON,
        K_NOTE_OFF,
        K_SKIP1,
        K_SKIP2
    } kind_t;

    kind_t          kind;
    logic           data_idx;
    logic [6:0]     held_note;
    logic [PW-1:0]  steal_ptr;
    logic [6:0]     note_r [NUM_VOICES];
    logic [6:0]     vel_r  [NUM_VOICES];

    logic                  chan_ok;
    logic [6:0]            data_byte;
    logic                  hit_any;
    logic [PW-1:0]         hit_idx;
    logic                  free_any;
    logic [PW-1:0]         free_idx;
    logic [NUM_VOICES-1:0] match_mask;

    // Allocation is resolved from the pre-message voice state and the held note.
    always_comb begin
        data_byte  = new_byte_value[6:0];
`ifdef MIDI_OMNI_EN
        chan_ok    = 1'b1;
`else
        chan_ok    = (new_byte_value[3:0] == 4'(CHANNEL));
`endif
        hit_any    = 1'b0;
        hit_idx    = '0;
        free_any   = 1'b0;
        free_idx   = '0;
        match_mask = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (voice_active[i] && (note_r[i] == held_note)) begin
                match_mask[i] = 1'b1;
                if (!hit_any) begin
                    hit_any = 1'b1;
                    hit_idx = PW'(i);
                end
            end
            if (!voice_active[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kind         <= K_NONE;
            data_idx     <= 1'b0;
            held_note    <= '0;
            steal_ptr    <= '0;
            voice_active <= '0;
            msg_valid    <= 1'b0;
            voice_stolen <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= '0;
                vel_r[i]  <= '0;
            end
        end else begin
            msg_valid    <= 1'b0;
            voice_stolen <= 1'b0;
            if (new_byte_valid) begin
                if (new_byte_value[7]) begin
                    if (new_byte_value < 8'hF0) begin
                        data_idx <= 1'b0;
                        case (new_byte_value[7:4])
                            4'h8:       kind <= chan_ok ? K_NOTE_OFF : K_SKIP2;
                            4'h9:       kind <= chan_ok ? K_NOTE_ON  : K_SKIP2;
                            4'hC, 4'hD: kind <= K_SKIP1;
                            default:    kind <= K_SKIP2;
                        endcase
                    end else if (new_byte_value < 8'hF8) begin
                        kind     <= K_NONE;
                        data_idx <= 1'b0;
                    end
                    // realtime bytes fall through untouched
                end else begin
                    case (kind)
                        K_SKIP1: data_idx <= 1'b0;
                        K_SKIP2: data_idx <= ~data_idx;
                        K_NOTE_ON, K_NOTE_OFF: begin
                            if (!data_idx) begin
                                held_note <= data_byte;
                                data_idx  <= 1'b1;
                            end else begin
                                data_idx  <= 1'b0;
                                msg_valid <= 1'b1;
                                if (kind == K_NOTE_ON && data_byte != 7'd0) begin
                                    if (hit_any) begin
                                        vel_r[hit_idx] <= data_byte;
                                    end else if (free_any) begin
                                        note_r[free_idx]       <= held_note;
                                        vel_r[free_idx]        <= data_byte;
                                        voice_active[free_idx] <= 1'b1;
                                    end else begin
                                        note_r[steal_ptr] <= held_note;
                                        vel_r[steal_ptr]  <= data_byte;
                                        voice_stolen      <= 1'b1;
                                        steal_ptr         <= (steal_ptr == PW'(NUM_VOICES - 1)) ?
                                                             '0 : steal_ptr + 1'b1;
                                    end
                                end else begin
                                    for (int i = 0; i < NUM_VOICES; i++) begin
                                        if (match_mask[i]) begin
                                            vel_r[i]        <= '0;
                                            voice_active[i] <= 1'b0;
                                        end
                                    end
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
        assign note_values[7*g +: 7]     = note_r[g];
        assign velocity_values[7*g +: 7] = vel_r[g];
    end

endmodule

// File: tb/tb_midi_poly_fsm.sv
// Testbench for midi_poly_fsm: directed scenarios plus randomized byte streams against a reference model.
module tb_midi_poly_fsm;

    localparam int NV = 4;

    logic            clk;
    logic            rst_n;
    logic            new_byte_valid;
    logic [7:0]      new_byte_value;
    logic [7*NV-1:0] note_values;
    logic [7*NV-1:0] velocity_values;
    logic [NV-1:0]   voice_active;
    logic            msg_valid;
    logic            voice_stolen;

    int checks   = 0;
    int failures = 0;
    int mv_cnt   = 0;
    int st_cnt   = 0;

    midi_poly_fsm #(.NUM_VOICES(NV), .CHANNEL(0)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .new_byte_valid  (new_byte_valid),
        .new_byte_value  (new_byte_value),
        .note_values     (note_values),
        .velocity_values (velocity_values),
        .voice_active    (voice_active),
        .msg_valid       (msg_valid),
        .voice_stolen    (voice_stolen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: parser state by message kind, voices as plain arrays.
    localparam int M_NONE = 0, M_ON = 1, M_OFF = 2, M_SKIP1 = 3, M_SKIP2 = 4;
    int         m_kind;
    int         m_pos;
    logic [6:0] m_held;
    logic [6:0] m_note [NV];
    logic [6:0] m_vel  [NV];
    logic       m_act  [NV];
    int         m_sp;
    logic       e_mv;
    logic       e_st;

    function automatic logic [6:0] vnote(input int i);
        return note_values[7*i +: 7];
    endfunction

    function automatic logic [6:0] vvel(input int i);
        return velocity_values[7*i +: 7];
    endfunction

    task automatic model_reset();
        m_kind = M_NONE;
        m_pos  = 0;
        m_held = '0;
        m_sp   = 0;
        e_mv   = 1'b0;
        e_st   = 1'b0;
        for (int i = 0; i < NV; i++) begin
            m_note[i] = '0;
            m_vel[i]  = '0;
            m_act[i]  = 1'b0;
        end
    endtask

    task automatic model_apply(input logic [6:0] v);
        int hit;
        int fr;
        e_mv = 1'b1;
        if (m_kind == M_ON && v != 0) begin
            hit = -1;
            fr  = -1;
            for (int i = NV - 1; i >= 0; i--) begin
                if (m_act[i] && m_note[i] == m_held) hit = i;
                if (!m_act[i]) fr = i;
            end
            if (hit >= 0) begin
                m_vel[hit] = v;
            end else if (fr >= 0) begin
                m_note[fr] = m_held;
                m_vel[fr]  = v;
                m_act[fr]  = 1'b1;
            end else begin
                m_note[m_sp] = m_held;
                m_vel[m_sp]  = v;
                e_st         = 1'b1;
                m_sp         = (m_sp + 1) % NV;
            end
        end else begin
            for (int i = 0; i < NV; i++) begin
                if (m_act[i] && m_note[i] == m_held) begin
                    m_vel[i] = '0;
                    m_act[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic accept;
        e_mv = 1'b0;
        e_st = 1'b0;
`ifdef MIDI_OMNI_EN
        accept = 1'b1;
`else
        accept = (b[3:0] == 4'd0);
`endif
        if (b >= 8'hF8) begin
            // realtime: no effect
        end else if (b >= 8'hF0) begin
            m_kind = M_NONE;
            m_pos  = 0;
        end else if (b >= 8'h80) begin
            m_pos = 0;
            if (b[7:4] == 4'h8)      m_kind = accept ? M_OFF : M_SKIP2;
            else if (b[7:4] == 4'h9) m_kind = accept ? M_ON : M_SKIP2;
            else if (b[7:4] == 4'hC || b[7:4] == 4'hD) m_kind = M_SKIP1;
            else m_kind = M_SKIP2;
        end else if (m_kind == M_SKIP2) begin
            m_pos = 1 - m_pos;
        end else if (m_kind == M_ON || m_kind == M_OFF) begin
            if (m_pos == 0) begin
                m_held = b[6:0];
                m_pos  = 1;
            end else begin
                m_pos = 0;
                model_apply(b[6:0]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (msg_valid)    mv_cnt++;
        if (voice_stolen) st_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        new_byte_valid = 1'b1;
        new_byte_value = b;
        tick();
        new_byte_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        send_byte(b);
        send_byte(c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        mv_cnt = 0;
        st_cnt = 0;
    endtask

    task automatic test_reset();
        // a strobe coincident with reset must be ignored
        rst_n          = 1'b0;
        new_byte_valid = 1'b1;
        new_byte_value = 8'h90;
        tick();
        tick();
        rst_n          = 1'b1;
        new_byte_valid = 1'b0;
        checks += 5;
        if (note_values !== '0) begin failures++; $display("FAIL reset_notes: got %h expected 0", note_values); end
        if (velocity_values !== '0) begin failures++; $display("FAIL reset_vel: got %h expected 0", velocity_values); end
        if (voice_active !== '0) begin failures++; $display("FAIL reset_active: got %b expected 0", voice_active); end
        if (msg_valid !== 1'b0) begin failures++; $display("FAIL reset_msg_valid: got %b expected 0", msg_valid); end
        if (voice_stolen !== 1'b0) begin failures++; $display("FAIL reset_stolen: got %b expected 0", voice_stolen); end
        send_byte(8'h41);
        send_byte(8'h10);
        checks++;
        if (voice_active !== '0 || mv_cnt != 0) begin
            failures++; $display("FAIL reset_override: active %b pulses %0d expected 0/0", voice_active, mv_cnt);
        end
        mv_cnt = 0;
        st_cnt = 0;
    endtask

    task automatic test_basic();
        do_reset();
        send3(8'h90, 8'h40, 8'h64);
        checks += 4;
        if (msg_valid !== 1'b1) begin failures++; $display("FAIL basic_msg_valid: got %b expected 1", msg_valid); end
        if (vnote(0) !== 7'h40) begin failures++; $display("FAIL basic_note: got %h expected 40", vnote(0)); end
        if (vvel(0) !== 7'h64) begin failures++; $display("FAIL basic_vel: got %h expected 64", vvel(0)); end
        if (voice_active !== 4'b0001) begin failures++; $display("FAIL basic_active: got %b expected 0001", voice_active); end
        tick();
        checks++;
        if (msg_valid !== 1'b0 || mv_cnt != 1) begin
            failures++; $display("FAIL basic_pulse: msg_valid %b pulses %0d expected 0/1", msg_valid, mv_cnt);
        end
    endtask

    task automatic test_running_status();
        do_reset();
        send3(8'h90, 8'h3C, 8'h50);
        send_byte(8'h3E); send_byte(8'h50);
        send_byte(8'h3C); send_byte(8'h7F);
        checks += 3;
        if (vnote(0) !== 7'h3C || vvel(0) !== 7'h7F) begin
            failures++; $display("FAIL rs_voice0: got %h/%h expected 3c/7f", vnote(0), vvel(0));
        end
        if (vnote(1) !== 7'h3E || vvel(1) !== 7'h50) begin
            failures++; $display("FAIL rs_voice1: got %h/%h expected 3e/50", vnote(1), vvel(1));
        end
        if (voice_active !== 4'b0011 || mv_cnt != 3) begin
            failures++; $display("FAIL rs_active: got %b pulses %0d expected 0011/3", voice_active, mv_cnt);
        end
    endtask

    task automatic test_note_off();
        mv_cnt = 0;
        send3(8'h80, 8'h3C, 8'h40);
        send3(8'h90, 8'h3E, 8'h00);
        checks += 3;
        if (voice_active !== 4'b0000 || mv_cnt != 2) begin
            failures++; $display("FAIL off_active: got %b pulses %0d expected 0000/2", voice_active, mv_cnt);
        end
        if (velocity_values !== '0) begin failures++; $display("FAIL off_vel: got %h expected 0", velocity_values); end
        if (vnote(0) !== 7'h3C || vnote(1) !== 7'h3E) begin
            failures++; $display("FAIL off_notes: got %h/%h expected 3c/3e", vnote(0), vnote(1));
        end
    endtask

    task automatic test_steal();
        do_reset();
        send_byte(8'h90);
        for (int n = 0; n < 4; n++) begin
            send_byte(8'h30 + 8'(n));
            send_byte(8'h10);
        end
        checks++;
        if (voice_active !== 4'b1111 || vnote(3) !== 7'h33 || st_cnt != 0) begin
            failures++; $display("FAIL steal_fill: active %b v3 %h stolen %0d expected 1111/33/0", voice_active, vnote(3), st_cnt);
        end
        send_byte(8'h34); send_byte(8'h10);
        checks += 2;
        if (voice_stolen !== 1'b1 || msg_valid !== 1'b1) begin
            failures++; $display("FAIL steal_pulse: stolen %b valid %b expected 1/1", voice_stolen, msg_valid);
        end
        if (vnote(0) !== 7'h34 || vnote(1) !== 7'h31) begin
            failures++; $display("FAIL steal_first: got %h/%h expected 34/31", vnote(0), vnote(1));
        end
        send_byte(8'h35); send_byte(8'h10);
        checks++;
        if (vnote(1) !== 7'h35 || vnote(2) !== 7'h32 || st_cnt != 2) begin
            failures++; $display("FAIL steal_second: v1 %h v2 %h stolen %0d expected 35/32/2", vnote(1), vnote(2), st_cnt);
        end
    endtask

    task automatic test_filter();
        do_reset();
        send_byte(8'h90); send_byte(8'hF8); send_byte(8'h41);
        send_byte(8'hFE); send_byte(8'h22);
        checks++;
        if (msg_valid !== 1'b1 || vnote(0) !== 7'h41 || vvel(0) !== 7'h22) begin
            failures++; $display("FAIL rt_voice0: valid %b got %h/%h expected 1/41/22", msg_valid, vnote(0), vvel(0));
        end
        send3(8'h91, 8'h42, 8'h22);
        checks++;
`ifdef MIDI_OMNI_EN
        if (voice_active !== 4'b0011 || vnote(1) !== 7'h42 || mv_cnt != 2) begin
            failures++; $display("FAIL chan_filter: active %b v1 %h pulses %0d expected 0011/42/2", voice_active, vnote(1), mv_cnt);
        end
`else
        if (voice_active !== 4'b0001 || vnote(1) !== 7'h00 || mv_cnt != 1) begin
            failures++; $display("FAIL chan_filter: active %b v1 %h pulses %0d expected 0001/00/1", voice_active, vnote(1), mv_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_byte(8'h90); send_byte(8'h40);
        do_reset();
        send3(8'h64, 8'h41, 8'h10);
        checks += 2;
        if (note_values !== '0 || velocity_values !== '0 || voice_active !== '0) begin
            failures++; $display("FAIL midrst_state: notes %h vel %h active %b expected 0", note_values, velocity_values, voice_active);
        end
        if (mv_cnt != 0) begin failures++; $display("FAIL midrst_pulses: got %0d expected 0", mv_cnt); end
        send3(8'h90, 8'h41, 8'h10);
        checks++;
        if (vnote(0) !== 7'h41 || vvel(0) !== 7'h10 || voice_active !== 4'b0001) begin
            failures++; $display("FAIL midrst_recover: got %h/%h %b expected 41/10/0001", vnote(0), vvel(0), voice_active);
        end
    endtask

    task automatic test_back_to_back_random();
        int r;
        logic [7:0] b;
        logic [NV-1:0] exp_act;
        do_reset();
        for (int it = 0; it < 1500; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)       b = (r < 4) ? 8'h90 : 8'h80;
            else if (r < 10) b = (r == 8) ? 8'h91 : 8'h81;
            else if (r < 14) b = 8'($urandom_range(8'hA0, 8'hEF));
            else if (r < 15) b = 8'($urandom_range(8'hF0, 8'hF7));
            else if (r < 21) b = 8'($urandom_range(8'hF8, 8'hFF));
            else if (r < 25) b = 8'h00;
            else             b = 8'($urandom_range(8'h30, 8'h37));
            if ($urandom_range(0, 4) == 0) begin
                tick();
                e_mv = 1'b0;
                e_st = 1'b0;
            end else begin
                send_byte(b);
                model_byte(b);
            end
            for (int i = 0; i < NV; i++) exp_act[i] = m_act[i];
            checks++;
            if (msg_valid !== e_mv || voice_stolen !== e_st || voice_active !== exp_act) begin
                failures++;
                $display("FAIL rnd_ctrl it=%0d byte=%h: valid %b stolen %b active %b expected %b %b %b",
                         it, b, msg_valid, voice_stolen, voice_active, e_mv, e_st, exp_act);
            end
            for (int i = 0; i < NV; i++) begin
                checks++;
                if (vnote(i) !== m_note[i] || vvel(i) !== m_vel[i]) begin
                    failures++;
                    $display("FAIL rnd_voice it=%0d v%0d: got %h/%h expected %h/%h",
                             it, i, vnote(i), vvel(i), m_note[i], m_vel[i]);
                end
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        new_byte_valid = 1'b0;
        new_byte_value = 8'h00;
        model_reset();
        test_reset();
        test_basic();
        test_running_status();
        test_note_off();
        test_steal();
        test_filter();
        test_reset_mid();
        test_back_to_back_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/midi_poly_fsm.md
# midi_poly_fsm

Parametrised polyphonic MIDI note parser and voice allocator, the successor to the single-voice `midi_fsm`. It sits between the UART byte receiver and the synthesis voices. It consumes one MIDI byte per valid strobe and tracks running status. It maps Note On/Off messages onto `NUM_VOICES` voice slots, with re-trigger, lowest-free allocation and round-robin stealing, and presents registered per-voice note, velocity and gate outputs.

## Interface
Parameters:
- `NUM_VOICES`, 4: number of voice slots, 1–16.
- `CHANNEL`, 0: MIDI channel 0–15 accepted when omni is compiled out.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset. Synchronous, active-low.
- `new_byte_valid`  in  1: one-cycle strobe; `new_byte_value` is valid this cycle.
- `new_byte_value`  in  8: received MIDI byte.
- `note_values`  out  7*NUM_VOICES: voice i note at bits [7*i +: 7].
- `velocity_values`  out  7*NUM_VOICES: voice i velocity at bits [7*i +: 7]; 0 when the voice is off.
- `voice_active`  out  NUM_VOICES: gate per voice.
- `msg_valid`  out  1: one-cycle pulse when a note message is applied.
- `voice_stolen`  out  1: one-cycle pulse, coincident with `msg_valid`, when allocation stole a voice.

## Operation
- **Byte classes**
  - Status: bit7 = 1.
  - Data: bit7 = 0.
  - Only bytes with `new_byte_valid` = 1 are examined. Strobes may arrive back-to-back, one per cycle.
- **Running-status kind register.** Values: NONE, NOTE_ON, NOTE_OFF, SKIP1, SKIP2. Plus a 1-bit data index and a 7-bit held note byte.
  - 0x9n on an accepted channel: NOTE_ON.
  - 0x8n on an accepted channel: NOTE_OFF.
  - 0x8n/0x9n on a rejected channel: SKIP2.
  - 0xAn, 0xBn, 0xEn: SKIP2.
  - 0xCn, 0xDn: SKIP1.
  - Every status byte 0x80–0xEF resets the data index to 0.
  - 0xF0–0xF7 sets NONE.
  - 0xF8–0xFF (realtime) are ignored entirely. Kind, index and held note are unchanged.
- **Data bytes**
  - Kind NONE: byte discarded.
  - SKIP1: byte consumed; index stays 0.
  - SKIP2: index toggles.
  - NOTE_ON/NOTE_OFF, index 0: store the note, set index to 1.
  - NOTE_ON/NOTE_OFF, index 1: apply the message with the stored note and this velocity, set index to 0.
  - The kind is retained after a message completes (running status).
- **Note On, velocity ≠ 0.** The first matching rule wins:
  1. A voice is active with the same note: update its velocity only (re-trigger).
  2. Otherwise, the lowest-index inactive voice receives note and velocity and becomes active.
  3. Otherwise, the voice at `steal_ptr` is overwritten and `voice_stolen` pulses. `steal_ptr` then increments, wrapping from NUM_VOICES−1 to 0.
- **Note Off.** Applies to 0x8n with any velocity, and to Note On with velocity 0.
  - Every active voice whose note matches gets velocity 0 and active 0. Its note value is retained.
  - An unmatched note off produces no state change but still pulses `msg_valid`.
- **Reset state.** `note_values` = 0, `velocity_values` = 0, `voice_active` = 0, `msg_valid` = 0, `voice_stolen` = 0, kind = NONE, index = 0, `steal_ptr` = 0.
  - Reset mid-message discards the partial message.
  - Subsequent data bytes are dropped until a new status byte arrives.

## Timing
- All outputs are registered.
- A message's final data byte is sampled at edge N. Voice outputs update and `msg_valid` / `voice_stolen` are high in the cycle after edge N. Latency is 1 cycle from the strobe.
- `msg_valid` and `voice_stolen` are high for exactly one cycle per message, including back-to-back messages.
- Allocation uses voice state as it was before the current message. Each message is resolved fully in one cycle, so consecutive messages one cycle apart see each other's results.
- Realtime bytes interleaved between data bytes add no latency beyond their own strobe.
- `rst_n` low at an edge overrides any byte strobed in the same cycle.

## Configuration
- `MIDI_OMNI_EN` defined: note messages on all 16 channels are accepted, and `CHANNEL` is ignored.
- `MIDI_OMNI_EN` undefined: only channel `CHANNEL` is accepted. Note messages on other channels are parsed as SKIP2, so their running-status data is also skipped.

## Test plan
All scenarios use NUM_VOICES = 4, CHANNEL = 0, omni off unless stated.
- **Basic note on.** 0x90, 0x40, 0x64 → one cycle after the third strobe:
  - voice 0 note 0x40, velocity 0x64;
  - `voice_active` = 4'b0001;
  - one `msg_valid` pulse.
- **Running status and re-trigger.** 0x90, 0x3C, 0x50, 0x3E, 0x50, 0x3C, 0x7F →
  - voice 0 = 0x3C, velocity 0x7F;
  - voice 1 = 0x3E, velocity 0x50;
  - `voice_active` = 4'b0011;
  - three `msg_valid` pulses.
- **Both note-off forms.** From the previous state, 0x80, 0x3C, 0x40 then 0x90, 0x3E, 0x00 →
  - `voice_active` = 0;
  - velocities 0;
  - note values 0x3C / 0x3E retained.
- **Stealing.** Note ons 0x30–0x34 at velocity 0x10 →
  - voices 0–3 = 0x30–0x33;
  - fifth note 0x34 replaces voice 0, `voice_stolen` pulses once;
  - a sixth note 0x35 replaces voice 1.
- **Filtering and realtime.**
  - 0x90, 0xF8, 0x41, 0xFE, 0x22 → voice 0 = 0x41, velocity 0x22.
  - 0x91, 0x42, 0x22 → no change with omni off.
  - The same sequence with `MIDI_OMNI_EN` → 0x42 allocated to the next free voice.
- **Reset mid-message.**
  - 0x90, 0x40, then `rst_n` low for one cycle, then 0x64, 0x41, 0x10 → all outputs 0, no `msg_valid`.
  - Subsequent 0x90, 0x41, 0x10 → voice 0 = 0x41.
